// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> [WB] with
// single-beat memory handshakes, sticky illegal-instruction halt and a retire counter.
module multicycle_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic [6:0]  opcode,
  input  logic [3:0]  alu_control,
  input  logic        regwrite_control,
  output logic        imem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        regfile_we,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [1:0] {ClsR, ClsI, ClsLoad, ClsStore} cls_e;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;

  state_e      state_q;
  cls_e        cls_q;
  cls_e        cls_dec;
  logic        op_legal;
  logic        halt_dec;
  logic        illegal_q;
  logic [31:0] instret_q;

  // Classify the live opcode; only consulted during DECODE.
  always_comb begin
    cls_dec  = ClsR;
    op_legal = 1'b1;
    case (opcode)
      OpR:     cls_dec = ClsR;
      OpI:     cls_dec = ClsI;
      OpLoad:  cls_dec = ClsLoad;
      OpStore: cls_dec = ClsStore;
      default: op_legal = 1'b0;
    endcase
    halt_dec = !op_legal ||
               (((cls_dec == ClsR) || (cls_dec == ClsI)) && (alu_control == 4'b1111));
  end

  // Strobes are forced low while reset is high so nothing completes in a reset cycle.
  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    regfile_we = 1'b0;
    if (!reset) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_write = imem_ready;
        end
        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == ClsStore);
          pc_write = (cls_q == ClsStore) && dmem_ready;
        end
        StWb: begin
          regfile_we = regwrite_control;
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      cls_q     <= ClsR;
      illegal_q <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      if (pc_write) begin
        instret_q <= instret_q + 32'd1;
      end
      case (state_q)
        StFetch: begin
          if (imem_ready) begin
            state_q <= StDecode;
          end
        end
        StDecode: begin
          if (halt_dec) begin
            state_q   <= StHalt;
            illegal_q <= 1'b1;
          end else begin
            cls_q   <= cls_dec;
            state_q <= StExec;
          end
        end
        StExec: begin
          if ((cls_q == ClsLoad) || (cls_q == ClsStore)) begin
            state_q <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (dmem_ready) begin
            state_q <= (cls_q == ClsStore) ? StFetch : StWb;
          end
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StFetch;
      endcase
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: each planned instruction is expanded into its expected
// cycle-by-cycle trace, which drives the inputs and is compared against the outputs.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic        dmem_ready;
  logic [6:0]  opcode;
  logic [3:0]  alu_control;
  logic        regwrite_control;
  logic        imem_req;
  logic        ir_write;
  logic        pc_write;
  logic        dmem_req;
  logic        dmem_we;
  logic        regfile_we;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instret;

  multicycle_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .imem_ready       (imem_ready),
    .dmem_ready       (dmem_ready),
    .opcode           (opcode),
    .alu_control      (alu_control),
    .regwrite_control (regwrite_control),
    .imem_req         (imem_req),
    .ir_write         (ir_write),
    .pc_write         (pc_write),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .regfile_we       (regfile_we),
    .state            (state),
    .illegal          (illegal),
    .instret          (instret)
  );

  always #5 clk = ~clk;

  localparam int KR = 0, KI = 1, KLOAD = 2, KSTORE = 3, KBADOP = 4, KBADALU = 5;

  typedef struct {
    bit          rst, imr, dmr, rwc;
    logic [6:0]  op;
    logic [3:0]  alu;
    logic [2:0]  st;
    bit          imq, irw, pcw, dmq, dwe, rfw, ill;
    logic [31:0] cnt;
    bit          chk;
  } cyc_t;

  cyc_t        tr[$];
  logic [31:0] m_cnt = 32'd0;
  bit          m_ill = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          cyc_idx = 0;

  function automatic cyc_t base();
    cyc_t r;
    r.rst = 1'b0; r.imr = 1'($urandom); r.dmr = 1'($urandom); r.rwc = 1'($urandom);
    r.op = 7'($urandom); r.alu = 4'($urandom); r.st = 3'd0;
    r.imq = 0; r.irw = 0; r.pcw = 0; r.dmq = 0; r.dwe = 0; r.rfw = 0;
    r.ill = 0; r.cnt = 0; r.chk = 1'b1;
    return r;
  endfunction

  task automatic emit(input cyc_t r);
    r.cnt = m_cnt;
    r.ill = m_ill;
    tr.push_back(r);
  endtask

  // A reset cycle shows the pre-reset state with all strobes low; counters clear after it.
  task automatic emit_reset(input logic [2:0] st);
    cyc_t r;
    r = base();
    r.rst = 1'b1;
    r.st  = st;
    emit(r);
    m_cnt = 32'd0;
    m_ill = 1'b0;
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return (op == 7'b0110011) || (op == 7'b0010011) || (op == 7'b0000011) ||
           (op == 7'b0100011);
  endfunction

  // rst_mem >= 0 aborts with reset on that MEM cycle; halt_n is the HALT dwell before reset.
  task automatic gen_instr(input int kind, input int fw, input int mw, input int rst_mem,
                           input int halt_n);
    cyc_t       r;
    logic [6:0] op;
    for (int k = 0; k <= fw; k++) begin
      r = base();
      r.imr = (k == fw); r.imq = 1'b1; r.irw = (k == fw);
      emit(r);
    end
    case (kind)
      KR:      op = 7'b0110011;
      KI:      op = 7'b0010011;
      KLOAD:   op = 7'b0000011;
      KSTORE:  op = 7'b0100011;
      KBADALU: op = ($urandom_range(0, 1) == 0) ? 7'b0110011 : 7'b0010011;
      default: begin
        op = 7'($urandom);
        while (legal_op(op)) op = 7'($urandom);
      end
    endcase
    r = base();
    r.st = 3'd1; r.op = op;
    if (kind == KBADALU) r.alu = 4'hF;
    else if (kind <= KI) r.alu = 4'($urandom_range(0, 14));
    emit(r);
    if (kind >= KBADOP) begin
      m_ill = 1'b1;
      for (int h = 0; h < halt_n; h++) begin
        r = base();
        r.st = 3'd5;
        emit(r);
      end
      emit_reset(3'd5);
      return;
    end
    r = base();
    r.st = 3'd2; r.imr = 1'b1;
    emit(r);
    if (kind >= KLOAD) begin
      for (int k = 0; k <= mw; k++) begin
        if (k == rst_mem) begin
          emit_reset(3'd3);
          return;
        end
        r = base();
        r.st = 3'd3; r.dmr = (k == mw); r.dmq = 1'b1; r.dwe = (kind == KSTORE);
        r.pcw = (kind == KSTORE) && (k == mw);
        emit(r);
        if (r.pcw) m_cnt = m_cnt + 32'd1;
      end
      if (kind == KSTORE) return;
    end
    r = base();
    r.st = 3'd4; r.pcw = 1'b1; r.rfw = r.rwc;
    emit(r);
    m_cnt = m_cnt + 32'd1;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_idx, act, exp);
    end
  endtask

  // Called at a negedge; drives each cycle, compares 1ns later, returns at the next negedge.
  task automatic play();
    cyc_t r;
    while (tr.size() > 0) begin
      r = tr.pop_front();
      reset = r.rst; imem_ready = r.imr; dmem_ready = r.dmr;
      opcode = r.op; alu_control = r.alu; regwrite_control = r.rwc;
      #1;
      if (r.chk) begin
        cmp("state", 32'(state), 32'(r.st));
        cmp("imem_req", 32'(imem_req), 32'(r.imq));
        cmp("ir_write", 32'(ir_write), 32'(r.irw));
        cmp("pc_write", 32'(pc_write), 32'(r.pcw));
        cmp("dmem_req", 32'(dmem_req), 32'(r.dmq));
        if (r.dmq) cmp("dmem_we", 32'(dmem_we), 32'(r.dwe));
        cmp("regfile_we", 32'(regfile_we), 32'(r.rfw));
        cmp("illegal", 32'(illegal), 32'(r.ill));
        cmp("instret", instret, r.cnt);
      end
      cyc_idx++;
      @(negedge clk);
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    #1;
    cmp(name, act, exp);
  endtask

  initial begin
    cyc_t r;
    reset = 1'b1; imem_ready = 0; dmem_ready = 0;
    opcode = 0; alu_control = 0; regwrite_control = 0;
    @(negedge clk);
    r = base(); r.rst = 1'b1; r.chk = 1'b0;
    tr.push_back(r);
    emit_reset(3'd0);
    play();
    lit("lit_reset_state", 32'(state), 32'd0);

    // ADD with regwrite: FETCH, DECODE, EXEC, WB.
    gen_instr(KR, 0, 0, -1, 0);
    tr[3].rwc = 1'b1; tr[3].rfw = 1'b1; tr[1].alu = 4'b0010;
    play();
    lit("lit_add_instret", instret, 32'd1);

    gen_instr(KLOAD, 0, 3, -1, 0);
    play();
    lit("lit_load_instret", instret, 32'd2);

    gen_instr(KSTORE, 0, 0, -1, 0);
    play();
    lit("lit_store_instret", instret, 32'd3);

    gen_instr(KBADOP, 0, 0, -1, 10);
    play();
    lit("lit_badop_cleared", 32'(illegal), 32'd0);

    gen_instr(KR, 1, 0, -1, 0);
    gen_instr(KBADALU, 0, 0, -1, 10);
    tr[tr.size() - 12].op = 7'b0110011;
    play();
    lit("lit_badalu_instret", instret, 32'd0);

    gen_instr(KR, 0, 0, -1, 0);
    gen_instr(KSTORE, 0, 3, 2, 0);
    play();
    lit("lit_memrst_instret", instret, 32'd0);
    lit("lit_memrst_state", 32'(state), 32'd0);

    // Preload the counter while idling one cycle in FETCH, then retire across the wrap.
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    force dut.instret_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instret_q;
    m_cnt = 32'hFFFF_FFFF;
    lit("lit_preload", instret, 32'hFFFF_FFFF);
    gen_instr(KI, 0, 0, -1, 0);
    play();
    lit("lit_wrap", instret, 32'd0);

    for (int n = 0; n < 150; n++) begin
      int sel, fw, mw;
      sel = $urandom_range(0, 19);
      fw  = $urandom_range(0, 3);
      mw  = $urandom_range(0, 3);
      if (sel <= 4)       gen_instr(KR, fw, mw, -1, 0);
      else if (sel <= 8)  gen_instr(KI, fw, mw, -1, 0);
      else if (sel <= 12) gen_instr(KLOAD, fw, mw, -1, 0);
      else if (sel <= 16) gen_instr(KSTORE, fw, mw, -1, 0);
      else if (sel == 17) gen_instr(KBADOP, fw, mw, -1, $urandom_range(1, 4));
      else if (sel == 18) gen_instr(KBADALU, fw, mw, -1, $urandom_range(1, 4));
      else                gen_instr(KSTORE, fw, mw, $urandom_range(0, mw), 0);
    end
    play();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and sits between the instruction register/PC, the combinational `control` decoder, the register file and the data-memory port. It issues single-beat request/ready handshakes to instruction and data memory, gates register-file and PC writes, halts on unsupported encodings, and counts retired instructions.

## Interface
Parameters:
- none. The state encoding and the 32-bit retire-counter width are fixed.

Ports:
- `clk`  in  1  — the single clock.
- `reset`  in  1  — synchronous, active-high reset.
- `imem_ready`  in  1  — instruction memory has valid data this cycle.
- `dmem_ready`  in  1  — data-memory access completes this cycle.
- `opcode`  in  7  — bits [6:0] of the instruction register.
- `alu_control`  in  4  — from the decoder; 4'b1111 means unsupported op.
- `regwrite_control`  in  1  — from the decoder.
- `imem_req`  out  1  — fetch request.
- `ir_write`  out  1  — load the instruction register.
- `pc_write`  out  1  — advance the PC (PC+4 selection is external).
- `dmem_req`  out  1  — data-memory request.
- `dmem_we`  out  1  — data-memory write enable; valid only while `dmem_req` is high.
- `regfile_we`  out  1  — register-file write enable.
- `state`  out  3  — current state, for debug.
- `illegal`  out  1  — sticky flag for an unsupported instruction.
- `instret`  out  32  — retired-instruction count.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 are unreachable; if entered, go to FETCH.
- Instruction class comes from `opcode` only:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - Anything else is illegal.
- FETCH:
  - `imem_req`=1.
  - When `imem_ready`=1: `ir_write`=1 for that cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle.
  - Go to HALT and set `illegal` if the opcode is illegal, or if the class is R/I and `alu_control`==4'b1111.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - LOAD/STORE go to MEM.
  - R/I go to WB.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STORE, 0 for LOAD.
  - Wait for `dmem_ready`.
  - On `dmem_ready`, LOAD goes to WB.
  - On `dmem_ready`, STORE retires: `pc_write`=1, `instret` increments, go to FETCH.
- WB: one cycle.
  - `regfile_we`=`regwrite_control`.
  - `pc_write`=1, `instret` increments, go to FETCH.
- HALT:
  - Every strobe output is 0.
  - Stays in HALT until `reset`.
- Output decoding:
  - `imem_req`, `dmem_req`, `dmem_we` and `regfile_we` are decoded from the current state (plus the latched class/inputs).
  - `ir_write` and `pc_write` are combinational ANDs of state with the corresponding ready (the retiring MEM cycle for STORE).
- Instruction class is latched at the DECODE→EXEC transition. Later changes on `opcode` do not alter the path.
- `instret` wraps 0xFFFF_FFFF → 0 with no flag.
- A ready input that arrives outside its waiting state is ignored: `imem_ready` outside FETCH, `dmem_ready` outside MEM.

## Timing
- Reset values, taking effect on the first clock edge with `reset`=1:
  - `state`=FETCH
  - `instret`=0
  - `illegal`=0
  - Every strobe output is 0 while `reset` is high.
- Reset mid-operation, in any state including HALT or a MEM wait: the next state is FETCH. No pending memory request is completed, and no PC or register write occurs in the reset cycle.
- Minimum latency per instruction, with ready already high on entry:
  - R/I: 4 cycles (FETCH, DECODE, EXEC, WB).
  - STORE: 4 cycles (FETCH, DECODE, EXEC, MEM).
  - LOAD: 5 cycles (FETCH, DECODE, EXEC, MEM, WB).
- Each cycle a ready is held low adds one cycle in FETCH or MEM. The request stays asserted for the whole wait.
- `instret` updates on the clock edge that ends the retiring cycle. It reads the new value in the cycle that follows, which is the next FETCH.
- `illegal` rises on the edge that enters HALT and stays high until reset.

## Test plan
- Reset, then an ADD (opcode 0110011, `alu_control`=0010) with `imem_ready`=1 → `state` 0,1,2,4,0; `regfile_we`=1 and `pc_write`=1 only in the WB cycle; `instret`=1.
- LOAD (0000011) with `dmem_ready` low for 3 MEM cycles → `dmem_req`=1 and `dmem_we`=0 for 4 cycles, then WB with `regfile_we`=1; 8 cycles total; `instret` increments by 1.
- STORE (0100011) with `dmem_ready`=1 → `dmem_we`=1 in MEM, `pc_write`=1 in the same cycle, `regfile_we` never asserted, next state FETCH.
- Opcode 1111111, then separately R-type with `alu_control`=1111 → HALT after DECODE; `illegal`=1; no further `imem_req` over 10 cycles; `reset` returns to FETCH with `illegal`=0.
- `reset` asserted during a MEM wait (STORE, `dmem_ready`=0) → next cycle FETCH, `dmem_req`=0, `instret`=0, no `pc_write`.
- Preload `instret` to 0xFFFF_FFFF by running instructions (or via a force) and retire one more → `instret`=0x0000_0000; `imem_ready` pulsed during EXEC is ignored.
